// File: rtl/integrador_dump_fixed.sv
// ---------------------------------------------------------------------------
// integrador_dump_fixed
//   Integrate-and-dump stage. Accumulates NDUMP valid S(NBI,NBFI) samples at
//   full precision (S(NBACC,NBFI), so the running sum can never overflow),
//   then quantises the sum to S(NBO,NBFO) with saturation and emits it with
//   a one-cycle o_valid strobe. o_data/o_sat are held between dumps.
//
//   Build option (macro): INTEG_ROUND_EN
//     defined   -> round half up (add 2^(D-1) before the shift)
//     undefined -> truncation (arithmetic shift, floor toward -inf)
//
//   Ports
//     i_clk    : clock, rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_valid  : i_data carries a sample this cycle
//     i_data   : sample, S(NBI,NBFI)
//     i_clear  : synchronous abort of the current window (beats i_valid)
//     o_valid  : one-cycle strobe, o_data/o_sat updated
//     o_data   : dumped result, S(NBO,NBFO)
//     o_sat    : saturation was applied to o_data
//     o_count  : samples accumulated in the current window
// ---------------------------------------------------------------------------
module integrador_dump_fixed #(
   parameter int NBI   = 9,
   parameter int NBFI  = 8,
   parameter int NDUMP = 8,
   parameter int NBO   = 8,
   parameter int NBFO  = 6,
   localparam int NBC   = $clog2(NDUMP),
   localparam int NBACC = NBI + NBC
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   input  logic [NBI-1:0] i_data,
   input  logic           i_clear,
   output logic           o_valid,
   output logic [NBO-1:0] o_data,
   output logic           o_sat,
   output logic [NBC-1:0] o_count
);

   // dropped LSBs between input and output fractional formats
   localparam int D = NBFI - NBFO;

   localparam logic [NBC-1:0] LAST = NBC'(NDUMP - 1);
   localparam logic [NBO-1:0] SAT_POS = {1'b0, {(NBO-1){1'b1}}};
   localparam logic [NBO-1:0] SAT_NEG = {1'b1, {(NBO-1){1'b0}}};

   logic signed [NBACC-1:0] r_acc;
   logic        [NBC-1:0]   r_count;

   logic signed [NBACC-1:0] w_sum;
   logic signed [NBACC:0]   w_ext;
   logic signed [NBACC:0]   w_rnd;
   logic signed [NBACC:0]   w_shr;
   logic                    w_ovf;
   logic        [NBO-1:0]   w_q;
   logic                    w_last;

   // running sum including this cycle's sample
   assign w_sum = r_acc + {{NBC{i_data[NBI-1]}}, i_data};

   // one guard bit so the rounding offset can never wrap the sum
   assign w_ext = {w_sum[NBACC-1], w_sum};

`ifdef INTEG_ROUND_EN
   assign w_rnd = w_ext + (NBACC+1)'(2 ** (D-1));
`else
   assign w_rnd = w_ext;
`endif

   assign w_shr = w_rnd >>> D;

   // result fits in NBO bits only if everything from the NBO sign bit up
   // is a copy of that sign bit
   assign w_ovf = !((&w_shr[NBACC:NBO-1]) || !(|w_shr[NBACC:NBO-1]));
   assign w_q   = w_ovf ? (w_shr[NBACC] ? SAT_NEG : SAT_POS) : w_shr[NBO-1:0];

   assign w_last = (r_count == LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc   <= '0;
         r_count <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sat   <= 1'b0;
      end else if (i_clear) begin
         // abort window; o_data/o_sat keep the last dump
         r_acc   <= '0;
         r_count <= '0;
         o_valid <= 1'b0;
      end else if (i_valid) begin
         if (w_last) begin
            o_data  <= w_q;
            o_sat   <= w_ovf;
            o_valid <= 1'b1;
            r_acc   <= '0;
            r_count <= '0;
         end else begin
            r_acc   <= w_sum;
            r_count <= r_count + 1'b1;
            o_valid <= 1'b0;
         end
      end else begin
         o_valid <= 1'b0;
      end
   end

   assign o_count = r_count;

endmodule

// File: tb/tb_integrador_dump_fixed.sv
// ---------------------------------------------------------------------------
// tb_integrador_dump_fixed
//   Directed test-plan sequences followed by randomised traffic, every cycle
//   compared against a window/queue reference model using real arithmetic.
// ---------------------------------------------------------------------------
module tb_integrador_dump_fixed;

   localparam int NBI = 9, NBFI = 8, NDUMP = 8, NBO = 8, NBFO = 6;
   localparam int NBC = $clog2(NDUMP);
   localparam int D   = NBFI - NBFO;

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic           i_valid;
   logic [NBI-1:0] i_data;
   logic           i_clear;
   logic           o_valid;
   logic [NBO-1:0] o_data;
   logic           o_sat;
   logic [NBC-1:0] o_count;

   integrador_dump_fixed #(
      .NBI(NBI), .NBFI(NBFI), .NDUMP(NDUMP), .NBO(NBO), .NBFO(NBFO)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .i_data (i_data),
      .i_clear(i_clear),
      .o_valid(o_valid),
      .o_data (o_data),
      .o_sat  (o_sat),
      .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int             win[$];
   bit             ev;
   logic [NBO-1:0] ed;
   bit             es;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // quantise a full-precision sum (in input LSBs) to the output format
   task automatic quant(input int sum, output logic [NBO-1:0] q8, output bit sat);
      real x;
      int  q;
      x = real'(sum) / real'(1 << D);
`ifdef INTEG_ROUND_EN
      x = x + 0.5;
`endif
      q = $rtoi($floor(x));
      if (q > 127) begin
         q8 = 8'h7F; sat = 1'b1;
      end else if (q < -128) begin
         q8 = 8'h80; sat = 1'b1;
      end else begin
         q8 = q[7:0]; sat = 1'b0;
      end
   endtask

   task automatic model(input bit v, input bit c, input logic [NBI-1:0] d);
      int sum;
      int sv;
      if (c) begin
         win.delete();
         ev = 0;
      end else if (v) begin
         sv = $signed(d);
         win.push_back(sv);
         if (win.size() == NDUMP) begin
            sum = 0;
            foreach (win[k]) sum += win[k];
            quant(sum, ed, es);
            ev = 1;
            win.delete();
         end else begin
            ev = 0;
         end
      end else begin
         ev = 0;
      end
   endtask

   task automatic check_all();
      chk("valid", {31'd0, o_valid}, {31'd0, ev});
      chk("data",  {24'd0, o_data},  {24'd0, ed});
      chk("sat",   {31'd0, o_sat},   {31'd0, es});
      chk("count", {29'd0, o_count}, 32'(win.size()));
   endtask

   // one clock: drive inputs, advance model at the edge, check 1 unit later
   task automatic cyc(input bit v, input bit c, input logic [NBI-1:0] d);
      i_valid = v; i_clear = c; i_data = d;
      @(posedge i_clk);
      model(v, c, d);
      #1;
      check_all();
   endtask

   task automatic feed(input int n, input logic [NBI-1:0] d);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, d);
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_data = '0;
      ev = 0; ed = '0; es = 0;
      #12;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_data",  {24'd0, o_data},  32'd0);
      chk("rst_sat",   {31'd0, o_sat},   32'd0);
      chk("rst_count", {29'd0, o_count}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // 8 x 0.125 -> 1.0
      feed(7, 9'h020);
      chk("tp1_cnt7", {29'd0, o_count}, 32'd7);
      feed(1, 9'h020);
      chk("tp1_valid", {31'd0, o_valid}, 32'd1);
      chk("tp1_data",  {24'd0, o_data},  32'h40);
      chk("tp1_sat",   {31'd0, o_sat},   32'd0);
      chk("tp1_wrap",  {29'd0, o_count}, 32'd0);

      // positive then negative saturation, back-to-back
      feed(8, 9'h080);
      chk("tp2_pos",  {24'd0, o_data}, 32'h7F);
      chk("tp2_psat", {31'd0, o_sat},  32'd1);
      feed(8, 9'h100);
      chk("tp2_neg",  {24'd0, o_data}, 32'h80);
      chk("tp2_nsat", {31'd0, o_sat},  32'd1);

      // rounding boundary
      feed(1, 9'h003); feed(7, 9'h000);
`ifdef INTEG_ROUND_EN
      chk("tp3_rnd_up", {24'd0, o_data}, 32'h01);
`else
      chk("tp3_trunc",  {24'd0, o_data}, 32'h00);
`endif
      chk("tp3_sat", {31'd0, o_sat}, 32'd0);
      feed(1, 9'h1FF); feed(7, 9'h000);
`ifdef INTEG_ROUND_EN
      chk("tp3_neg_rnd",   {24'd0, o_data}, 32'h00);
`else
      chk("tp3_neg_trunc", {24'd0, o_data}, 32'hFF);
`endif

      // gapped input, then hold
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, 9'h020);
         cyc(1'b0, 1'b0, 9'h155);
      end
      chk("tp4_hold", {24'd0, o_data}, 32'h40);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 9'h0AA);
      chk("tp4_novalid", {31'd0, o_valid}, 32'd0);

      // clear with a 6th sample, then a fresh window
      feed(5, 9'h080);
      cyc(1'b1, 1'b1, 9'h080);
      chk("tp5_clr_cnt", {29'd0, o_count}, 32'd0);
      feed(7, 9'h020);
      chk("tp5_nostrobe", {31'd0, o_valid}, 32'd0);
      feed(1, 9'h020);
      chk("tp5_data", {24'd0, o_data}, 32'h40);

      // clear on the dump cycle
      feed(7, 9'h080);
      cyc(1'b1, 1'b1, 9'h080);
      chk("tp5b_nodump", {31'd0, o_valid}, 32'd0);
      chk("tp5b_held",   {24'd0, o_data},  32'h40);

      // asynchronous reset mid-window
      feed(8, 9'h080);          // o_data now 0x7F so the reset is visible
      feed(3, 9'h020);
      i_valid = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      win.delete(); ev = 0; ed = '0; es = 0;
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_data",  {24'd0, o_data},  32'd0);
      chk("arst_sat",   {31'd0, o_sat},   32'd0);
      chk("arst_count", {29'd0, o_count}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      feed(8, 9'h020);
      chk("arst_after", {24'd0, o_data}, 32'h40);

      // randomised traffic
      for (int k = 0; k < 3000; k++) begin
         bit             v, c;
         logic [NBI-1:0] d;
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 40) == 0);
         case ($urandom_range(0, 3))
            0:       d = NBI'($urandom_range(0, 7));
            1:       d = NBI'(9'h1F8 + $urandom_range(0, 7));
            default: d = NBI'($urandom);
         endcase
         cyc(v, c, d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/integrador_dump_fixed.md
# integrador_dump_fixed

Integrate-and-dump stage for the fixed-point receive chain. Sits directly downstream of the parameterised fixed-point adder and consumes its rounded/saturated S(9,8) output. It accumulates NDUMP valid samples at full precision, then emits one rounded, saturated S(NBO,NBFO) result with a single-cycle valid strobe. Full-precision accumulation means no intermediate overflow is possible.

## Interface
- NBI, 9: input word width, signed.
- NBFI, 8: input fractional bits; input format S(NBI,NBFI).
- NDUMP, 8: samples per dump, ≥2.
- NBO, 8: output word width, signed.
- NBFO, 6: output fractional bits; NBFO < NBFI required; output format S(NBO,NBFO).
- Derived: NBC = $clog2(NDUMP); NBACC = NBI + NBC (full-precision sum, S(NBACC,NBFI)).
- clock, input, 1: single clock, rising edge.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_valid, input, 1: i_data is a sample this cycle.
- i_data, input, NBI: sample, S(NBI,NBFI).
- i_clear, input, 1: synchronous abort of the current integration window.
- o_valid, output, 1: one-cycle strobe, o_data updated.
- o_data, output, NBO: dumped result, S(NBO,NBFO); held between dumps.
- o_sat, output, 1: saturation applied to the current o_data; held with o_data.
- o_count, output, NBC: samples accumulated in the current window.

## Operation
- Reset (i_rst_n=0, asynchronous): acc=0, o_count=0, o_valid=0, o_data=0, o_sat=0.
- i_clear=1: acc←0 and o_count←0. A same-cycle i_valid sample is discarded. o_valid←0. o_data and o_sat are held. i_clear has priority over i_valid.
- i_valid=1 with o_count<NDUMP-1: acc←acc+sext(i_data), o_count←o_count+1, o_valid←0.
- i_valid=1 with o_count=NDUMP-1 (dump):
  - Form sum = acc+sext(i_data) in NBACC bits.
  - Register the quantised sum into o_data/o_sat.
  - o_valid←1; acc←0; o_count←0.
- i_valid=0: state held; o_valid←0.
- Quantisation, with D = NBFI-NBFO dropped LSBs:
  - Sign-extend sum to NBACC+1 bits.
  - Add 2^(D-1) (round half up, toward +∞ on ties), then arithmetic shift right by D.
  - Saturate to NBO bits.
  - Overflow: when the dropped-to-NBO upper bits are not all equal. o_data←0x7F…F if positive, 0x80…0 if negative. o_sat←1, else o_sat←0.
- No backpressure; the consumer must accept o_valid whenever it is asserted.

## Timing
- Dump latency: o_valid and o_data appear one cycle after the clock edge that accepts the NDUMP-th sample.
- o_valid is never high for two consecutive cycles with NDUMP≥2. A full-rate input (i_valid always 1) gives one strobe every NDUMP cycles.
- A sample accepted in the cycle after a dump starts the new window; there is no dead cycle.
- Reset asserted mid-window discards the partial sum. After release, the first i_valid is sample 0.
- i_clear on the dump cycle (o_count=NDUMP-1, i_valid=1): no dump and no o_valid; the window restarts.

## Configuration
- INTEG_ROUND_EN defined: round half up as in Operation.
- INTEG_ROUND_EN undefined: plain truncation (arithmetic shift right by D, floor toward −∞). Saturation logic is unchanged.

## Test plan
- Default parameters, 8×0x020 (0.125) back-to-back → o_valid one cycle after the 8th sample; o_data=0x40 (1.0); o_sat=0; o_count wraps 7→0.
- 8×0x080 (0.5) → o_data=0x7F, o_sat=1. Then 8×0x100 (−1.0) → o_data=0x80, o_sat=1.
- Rounding: samples 0x003 followed by 7×0x000 → o_data=0x01 with INTEG_ROUND_EN, 0x00 without. Samples 0x1FF (−1/256) followed by 7×0x000 → 0x00 with INTEG_ROUND_EN, 0xFF without.
- Gapped input: 8×0x020 with i_valid toggling 1/0 → single dump, o_data=0x40; o_data held at 0x40 and o_valid=0 until the next dump.
- Feed 5×0x080, assert i_clear together with a 6th sample, then feed 8×0x020 → o_data=0x40; no strobe before the 8th new sample.
- Pull i_rst_n low asynchronously (between edges) after 3 samples → all outputs 0 immediately. After release, 8×0x020 → o_data=0x40.
